// File: rtl/ram_wait_ctrl_pkg.sv
// ram_wait_ctrl_pkg: access size codes, FSM state encoding and the access legality check
package ram_wait_ctrl_pkg;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  function automatic logic bad_access(input logic [1:0] ty, input logic [1:0] a);
    return ty == 2'b11 || (ty == HALF && a[0]) || (ty == WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/ram_wait_ctrl_if.sv
// ram_wait_ctrl_if: request (MOV RW typeData Address DataIn) and response (DataOut MOC FAULT BUSY) bus
interface ram_wait_ctrl_if #(parameter int AW = 8);
  logic MOV;
  logic RW;
  logic [1:0] typeData;
  logic [AW-1:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic MOC;
  logic FAULT;
  logic BUSY;
  modport master (output MOV, RW, typeData, Address, DataIn, input DataOut, MOC, FAULT, BUSY);
  modport slave (input MOV, RW, typeData, Address, DataIn, output DataOut, MOC, FAULT, BUSY);
endinterface

// File: rtl/ram_wait_ctrl_wait_counter.sv
// wait_counter: loadable down-counter (clk rst load dec init) whose registered zero flag trails the count by one cycle
module wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] init,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      zero <= 1'b0;
    end else if (load) begin
      cnt <= init;
      zero <= 1'b0;
    end else if (dec) begin
      cnt <= cnt - 4'(cnt != 4'd0);
      zero <= cnt == 4'd0;
    end
endmodule

// File: rtl/ram_wait_ctrl.sv
// ram_wait_ctrl: big-endian byte RAM with wait states; CLK CLR plus bus slave (MOV RW typeData Address DataIn / DataOut MOC FAULT BUSY)
module ram_wait_ctrl
  import ram_wait_ctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 2,
  parameter int AW = $clog2(DEPTH)
) (
  input logic CLK,
  input logic CLR,
  ram_wait_ctrl_if.slave bus
);
  logic [7:0] mem [0:DEPTH-1];
  state_t state, next_state;
  logic rw_q;
  logic [1:0] ty_q;
  logic [AW-1:0] a_q, a1, a2, a3;
  logic [31:0] d_q, rd;
  logic zero, bad, fire, moc_d, fault_d, busy_d;
  wait_counter u_cnt (
    .clk (CLK),
    .rst (CLR),
    .load(state == IDLE && bus.MOV),
    .dec (state == WAIT),
    .init(4'(WAIT_STATES)),
    .zero(zero)
  );
  assign a1 = a_q + AW'(1);
  assign a2 = a_q + AW'(2);
  assign a3 = a_q + AW'(3);
  assign bad = bad_access(ty_q, a_q[1:0]);
  assign fire = state == WAIT && zero;
  assign rd = ty_q == BYTE ? {24'b0, mem[a_q]} :
              ty_q == HALF ? {16'b0, mem[a_q], mem[a1]} :
                             {mem[a_q], mem[a1], mem[a2], mem[a3]};
  always_comb
    next_state = state == IDLE ? (bus.MOV ? WAIT : IDLE) :
                 state == WAIT ? (zero ? DONE : WAIT) :
                                 (bus.MOV ? DONE : IDLE);
  always_comb begin
    moc_d = next_state == DONE;
    busy_d = next_state != IDLE;
    fault_d = fire ? bad : (next_state == DONE && bus.FAULT);
  end
  always_ff @(posedge CLK)
    if (CLR) begin
      state <= IDLE;
      bus.MOC <= 1'b0;
      bus.FAULT <= 1'b0;
      bus.BUSY <= 1'b0;
      bus.DataOut <= '0;
    end else begin
      state <= next_state;
      bus.MOC <= moc_d;
      bus.FAULT <= fault_d;
      bus.BUSY <= busy_d;
      if (fire && rw_q && !bad) bus.DataOut <= rd;
    end
  always_ff @(posedge CLK)
    if (!CLR && state == IDLE && bus.MOV) begin
      rw_q <= bus.RW;
      ty_q <= bus.typeData;
      a_q <= bus.Address;
      d_q <= bus.DataIn;
    end
  always_ff @(posedge CLK)
    if (!CLR && fire && !rw_q && !bad) begin
      if (ty_q == BYTE) mem[a_q] <= d_q[7:0];
      else if (ty_q == HALF) begin
        mem[a_q] <= d_q[15:8];
        mem[a1] <= d_q[7:0];
      end else begin
        mem[a_q] <= d_q[31:24];
        mem[a1] <= d_q[23:16];
        mem[a2] <= d_q[15:8];
        mem[a3] <= d_q[7:0];
      end
    end
endmodule

// File: tb/tb_ram_wait_ctrl.sv
// tb_ram_wait_ctrl: two instances (256 B / 2 wait states, 1024 B / 0 wait states) checked against a byte-array model
module tb_ram_wait_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  ram_wait_ctrl_if #(.AW(8)) ia ();
  ram_wait_ctrl_if #(.AW(10)) ib ();
  ram_wait_ctrl #(.DEPTH(256), .WAIT_STATES(2)) u_a (.CLK(clk), .CLR(clr), .bus(ia));
  ram_wait_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) u_b (.CLK(clk), .CLR(clr), .bus(ib));
  int total = 0;
  int bad = 0;
  logic [7:0] ma [0:255];
  logic [7:0] mb [0:1023];
  logic [31:0] da = '0, db = '0;
  logic s = 1'b0;
  wire moc = s ? ib.MOC : ia.MOC;
  wire fault = s ? ib.FAULT : ia.FAULT;
  wire busy = s ? ib.BUSY : ia.BUSY;
  wire [31:0] dout = s ? ib.DataOut : ia.DataOut;

  function automatic logic [7:0] mrd(input int a);
    return s ? mb[a] : ma[a];
  endfunction
  function automatic void mwr(input int a, input logic [7:0] v);
    if (s) mb[a] = v;
    else ma[a] = v;
  endfunction
  function automatic void expect_acc(input logic rw, input logic [1:0] ty, input int a,
                                     input logic [31:0] d, output logic [31:0] ed, output logic ef);
    int n;
    logic [31:0] v;
    n = ty == 2'd0 ? 1 : ty == 2'd1 ? 2 : 4;
    ef = ty == 2'd3 || (a % n) != 0;
    if (!ef) begin
      if (rw) begin
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'b0, mrd(a + i)};
        if (s) db = v;
        else da = v;
      end else
        for (int i = 0; i < n; i++) mwr(a + i, 8'(d >> (8 * (n - 1 - i))));
    end
    ed = s ? db : da;
  endfunction

  task automatic put(input logic mov, input logic rw, input logic [1:0] ty, input int a, input logic [31:0] d);
    if (s) begin
      ib.MOV = mov; ib.RW = rw; ib.typeData = ty; ib.Address = a[9:0]; ib.DataIn = d;
    end else begin
      ia.MOV = mov; ia.RW = rw; ia.typeData = ty; ia.Address = a[7:0]; ia.DataIn = d;
    end
  endtask

  task automatic xfer(input logic rw, input logic [1:0] ty, input int a, input logic [31:0] d, input int hold,
                      output int lat, output logic [31:0] o, output logic f, output logic held,
                      output logic moc_end, output logic busy_end);
    put(1'b1, rw, ty, a, d);
    @(posedge clk);
    #1 put(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 1023)), $urandom);
    lat = 0;
    held = 1'b1;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!moc && lat < 40);
    o = dout;
    f = fault;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (moc !== 1'b1) held = 1'b0;
    end
    put(1'b0, rw, ty, a, d);
    @(posedge clk);
    @(negedge clk);
    moc_end = moc;
    busy_end = busy;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    s = 1'b1; put(1'b0, 1'b0, 2'd0, 0, '0);
    s = 1'b0; put(1'b0, 1'b0, 2'd0, 0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ia.MOC !== 1'b0) begin bad++; $display("FAIL reset_moc_a got=%b want=0", ia.MOC); end
    total++; if (ia.FAULT !== 1'b0) begin bad++; $display("FAIL reset_fault_a got=%b want=0", ia.FAULT); end
    total++; if (ia.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b want=0", ia.BUSY); end
    total++; if (ia.DataOut !== 32'h0) begin bad++; $display("FAIL reset_dout_a got=%h want=0", ia.DataOut); end
    total++; if (ib.MOC !== 1'b0) begin bad++; $display("FAIL reset_moc_b got=%b want=0", ib.MOC); end
    total++; if (ib.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy_b got=%b want=0", ib.BUSY); end
    total++; if (ib.DataOut !== 32'h0) begin bad++; $display("FAIL reset_dout_b got=%h want=0", ib.DataOut); end
    clr = 1'b0;
  endtask

  task automatic test_word_read();
    int lat; logic [31:0] o, ed; logic f, ef, h, me, be;
    s = 1'b0;
    ma[0] = 8'hE3; ma[1] = 8'hA0; ma[2] = 8'h10; ma[3] = 8'h05;
    for (int i = 0; i < 4; i++) u_a.mem[i] = ma[i];
    expect_acc(1'b1, 2'd2, 0, '0, ed, ef);
    xfer(1'b1, 2'd2, 0, '0, 0, lat, o, f, h, me, be);
    total++; if (lat != 4) begin bad++; $display("FAIL word_read_latency got=%0d want=4", lat); end
    total++; if (o !== 32'hE3A01005) begin bad++; $display("FAIL word_read_data got=%h want=e3a01005", o); end
    total++; if (f !== 1'b0) begin bad++; $display("FAIL word_read_fault got=%b want=0", f); end
    total++; if (me !== 1'b0 || be !== 1'b0) begin bad++; $display("FAIL word_read_release got=%b%b want=00", me, be); end
  endtask

  task automatic test_half_write();
    int lat; logic [31:0] o, ed; logic f, ef, h, me, be;
    s = 1'b0;
    expect_acc(1'b0, 2'd1, 6, 32'h0000BEEF, ed, ef);
    xfer(1'b0, 2'd1, 6, 32'h0000BEEF, 0, lat, o, f, h, me, be);
    total++; if (f !== 1'b0 || o !== 32'hE3A01005) begin bad++; $display("FAIL half_write got=%b/%h want=0/e3a01005", f, o); end
    expect_acc(1'b1, 2'd0, 6, '0, ed, ef);
    xfer(1'b1, 2'd0, 6, '0, 0, lat, o, f, h, me, be);
    total++; if (o !== 32'h000000BE) begin bad++; $display("FAIL byte_read6 got=%h want=000000be", o); end
    expect_acc(1'b1, 2'd0, 7, '0, ed, ef);
    xfer(1'b1, 2'd0, 7, '0, 0, lat, o, f, h, me, be);
    total++; if (o !== 32'h000000EF) begin bad++; $display("FAIL byte_read7 got=%h want=000000ef", o); end
  endtask

  task automatic test_faults();
    int lat; logic [31:0] o, ed; logic f, ef, h, me, be;
    logic [1:0] tys [3] = '{2'd2, 2'd1, 2'd3};
    int as [3] = '{2, 1, 0};
    s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_acc(1'b1, tys[k], as[k], '0, ed, ef);
      xfer(1'b1, tys[k], as[k], '0, 0, lat, o, f, h, me, be);
      total++; if (f !== 1'b1 || lat != 4) begin bad++; $display("FAIL fault_%0d fault=%b lat=%0d want=1/4", k, f, lat); end
      total++; if (o !== 32'h000000EF) begin bad++; $display("FAIL fault_dout_%0d got=%h want=000000ef", k, o); end
    end
    expect_acc(1'b1, 2'd2, 0, '0, ed, ef);
    xfer(1'b1, 2'd2, 0, '0, 0, lat, o, f, h, me, be);
    total++; if (f !== 1'b0 || o !== 32'hE3A01005) begin bad++; $display("FAIL after_fault got=%b/%h want=0/e3a01005", f, o); end
  endtask

  task automatic test_clr_abort();
    int lat; logic [31:0] o, ed; logic f, ef, h, me, be, rose;
    s = 1'b0;
    rose = 1'b0;
    put(1'b1, 1'b0, 2'd2, 8, 32'h12345678);
    @(posedge clk);
    @(negedge clk); rose |= moc;
    @(posedge clk);
    @(negedge clk); rose |= moc;
    clr = 1'b1;
    put(1'b0, 1'b0, 2'd2, 8, 32'h12345678);
    @(posedge clk);
    @(negedge clk); rose |= moc;
    clr = 1'b0;
    da = '0; db = '0;
    total++; if (rose !== 1'b0) begin bad++; $display("FAIL abort_moc got=%b want=0", rose); end
    total++; if (busy !== 1'b0 || dout !== 32'h0) begin bad++; $display("FAIL abort_state busy=%b dout=%h want=0/0", busy, dout); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (moc !== 1'b0) begin bad++; $display("FAIL abort_late_moc got=%b want=0", moc); end
    expect_acc(1'b1, 2'd2, 8, '0, ed, ef);
    xfer(1'b1, 2'd2, 8, '0, 0, lat, o, f, h, me, be);
    total++; if (o !== ed || f !== 1'b0) begin bad++; $display("FAIL abort_readback got=%h/%b want=%h/0", o, f, ed); end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] o, ed; logic f, ef, h, me, be;
    s = 1'b1;
    expect_acc(1'b1, 2'd2, 16, '0, ed, ef);
    xfer(1'b1, 2'd2, 16, '0, 5, lat, o, f, h, me, be);
    total++; if (lat != 2) begin bad++; $display("FAIL hold_latency got=%0d want=2", lat); end
    total++; if (h !== 1'b1) begin bad++; $display("FAIL hold_moc got=%b want=1", h); end
    total++; if (me !== 1'b0 || be !== 1'b0) begin bad++; $display("FAIL hold_release got=%b%b want=00", me, be); end
    total++; if (o !== ed) begin bad++; $display("FAIL hold_data got=%h want=%h", o, ed); end
  endtask

  task automatic test_deep();
    int lat; logic [31:0] o, ed, v; logic f, ef, h, me, be;
    s = 1'b1;
    v = $urandom;
    expect_acc(1'b0, 2'd2, 1020, v, ed, ef);
    xfer(1'b0, 2'd2, 1020, v, 0, lat, o, f, h, me, be);
    expect_acc(1'b1, 2'd2, 1020, '0, ed, ef);
    xfer(1'b1, 2'd2, 1020, '0, 0, lat, o, f, h, me, be);
    total++; if (o !== v || f !== 1'b0) begin bad++; $display("FAIL deep_word got=%h/%b want=%h/0", o, f, v); end
  endtask

  task automatic test_random();
    int lat, a, hold, n; logic [31:0] o, ed, d; logic f, ef, h, me, be, rw; logic [1:0] ty;
    for (int k = 0; k < 80; k++) begin
      s = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ty = 2'($urandom_range(0, 3));
      n = ty == 2'd0 ? 1 : ty == 2'd1 ? 2 : 4;
      a = int'($urandom_range(0, s ? 1023 : 255));
      if ($urandom_range(0, 3) != 0) a = a - (a % n);
      d = $urandom;
      hold = int'($urandom_range(0, 2));
      expect_acc(rw, ty, a, d, ed, ef);
      xfer(rw, ty, a, d, hold, lat, o, f, h, me, be);
      total++; if (lat != (s ? 2 : 4)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", k, lat, s ? 2 : 4); end
      total++; if (o !== ed || f !== ef) begin bad++; $display("FAIL rnd%0d_result got=%h/%b want=%h/%b", k, o, f, ed, ef); end
      total++; if (h !== 1'b1 || me !== 1'b0 || be !== 1'b0) begin bad++; $display("FAIL rnd%0d_handshake got=%b%b%b want=100", k, h, me, be); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ma[i] = 8'($urandom); u_a.mem[i] = ma[i]; end
    for (int i = 0; i < 1024; i++) begin mb[i] = 8'($urandom); u_b.mem[i] = mb[i]; end
    test_reset();
    test_word_read();
    test_half_write();
    test_faults();
    test_clr_abort();
    test_hold();
    test_deep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_wait_ctrl.md
RAM_WAIT_CTRL -- requirements
Module: ram_wait_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, memory size in bytes; power of two, minimum 8.
REQ-002 SHALL have parameter WAIT_STATES, default 2, added access latency in cycles; range 0..15.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), address width.
REQ-004 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port CLR  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port MOV  input  1  memory operation valid; request held high until MOC is seen.
REQ-007 SHALL have port RW  input  1  1 = read, 0 = write.
REQ-008 SHALL have port typeData  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port Address  input  AW  byte address.
REQ-010 SHALL have port DataIn  input  32  write data, right-justified.
REQ-011 SHALL have port DataOut  output  32  read data, right-justified and zero-extended.
REQ-012 SHALL have port MOC  output  1  memory operation complete.
REQ-013 SHALL have port FAULT  output  1  access rejected; valid while MOC is high.
REQ-014 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; all outputs registered.
REQ-016 In IDLE with MOV=1, SHALL latch RW, typeData, Address and DataIn, load the wait counter with WAIT_STATES, and enter WAIT; inputs are ignored thereafter until IDLE.
REQ-017 In WAIT, SHALL decrement the counter each cycle; with counter = 0, SHALL perform the access and enter DONE; MOC rises exactly WAIT_STATES+2 edges after the edge that sampled MOV.
REQ-018 In DONE, SHALL hold MOC=1 while MOV=1; when MOV=0, SHALL return to IDLE with MOC=0 on that edge. A new request needs MOV low for at least one cycle.
REQ-019 Byte order SHALL be big-endian: mem[A] is the most-significant byte of a halfword or word at A.
REQ-020 A read SHALL update DataOut at the same edge MOC rises; DataOut SHALL hold until the next successful read.
REQ-021 A write SHALL store DataIn[7:0], [15:0] or [31:0] according to size, and SHALL NOT change DataOut.
REQ-022 SHALL assert FAULT with MOC, perform no memory write and leave DataOut unchanged when any of: typeData=11; halfword with Address[0]=1; word with Address[1:0]!=0.
REQ-023 Because of REQ-022 alignment, accesses SHALL never cross DEPTH; no wrap-around is required.
REQ-024 FAULT SHALL be cleared on leaving DONE.

Reset
REQ-025 CLR=1 SHALL force IDLE, MOC=0, FAULT=0, BUSY=0, DataOut=0 and counter=0 on the next edge, including mid-WAIT; the aborted write SHALL NOT occur.
REQ-026 CLR SHALL NOT clear memory contents; CLR has priority over MOV.

Structure
REQ-027 Storage SHALL be a byte array named mem[0:DEPTH-1], so benches can preload it hierarchically.
REQ-028 A shared package SHALL hold the typeData size codes (BYTE, HALF, WORD) and the FSM state encodings.
REQ-029 The wait-state counter SHALL be one sub-module, wait_counter (load, decrement, zero flag); everything else stays in ram_wait_ctrl.

Verification
REQ-030 Preload mem[0..3]=8'hE3,8'hA0,8'h10,8'h05, WAIT_STATES=2; word read at 0 -> MOC high 4 edges after MOV sampled, DataOut=32'hE3A01005, FAULT=0.
REQ-031 Halfword write 32'h0000BEEF to 6, then byte reads at 6 and 7 -> DataOut 32'h000000BE then 32'h000000EF.
REQ-032 Word read at 2, halfword read at 1, and typeData=11 -> each gives MOC=1, FAULT=1 and DataOut unchanged; a following word read at 0 gives FAULT=0.
REQ-033 Word write 32'h12345678 to 8 with CLR pulsed during WAIT -> MOC never rises, BUSY=0 after the CLR edge, and word read at 8 returns the prior contents.
REQ-034 WAIT_STATES=0 -> MOC 2 edges after MOV sampled; hold MOV 5 cycles -> MOC stays high; drop MOV -> MOC low next edge and BUSY=0.
REQ-035 DEPTH=1024 -> word write then read at address 1020 -> returns the written value with FAULT=0.
